stream_dwc_down: RTL
====================

# stream_dwc_down

Streaming data-width down-converter that reads wide words from the output end of a `StreamingFIFO_*` instance and emits them as narrower words. Its primary use is 72-bit FIFO words split into 24-bit beats. It sits between a FIFO's `out_V` stream and a narrower consumer layer, with full AXI-Stream valid/ready handshaking on both sides. Each input word is split into `RATIO = IN_WIDTH/OUT_WIDTH` slices, emitted least-significant slice first, at one slice per cycle with no bubbles between words.

## Interface
- `IN_WIDTH`, default 72: input word width. Must be an integer multiple of `OUT_WIDTH`.
- `OUT_WIDTH`, default 24: output beat width.
- `RATIO`, derived as `IN_WIDTH/OUT_WIDTH` (default 3). Not overridable.
- `CNT_W`, derived as `$clog2(RATIO+1)`.
- Clock: single clock `ap_clk`. Reset: `ap_rst`, asynchronous, active-high. This naming, polarity and synchronicity are fixed.

Ports:
- `ap_clk`  in  1  clock; all state changes on the rising edge.
- `ap_rst`  in  1  asynchronous active-high reset.
- `in0_V_TDATA`  in  `IN_WIDTH`  wide input word.
- `in0_V_TVALID`  in  1  input word valid.
- `in0_V_TREADY`  out  1  converter can accept a word this cycle.
- `out_V_TDATA`  out  `OUT_WIDTH`  current slice.
- `out_V_TVALID`  out  1  slice valid.
- `out_V_TREADY`  in  1  downstream accepts the slice.
- `count`  out  `CNT_W`  number of slices still held, including the one currently presented (range 0..`RATIO`).

## Operation
- State:
  - `buf`, an `IN_WIDTH`-bit register holding the current word.
  - `buf_v`, 1 bit, set while `buf` holds unsent slices.
  - `idx`, an index counter over 0..`RATIO`-1.
- Two states, EMPTY (`buf_v`=0) and HOLD (`buf_v`=1).
- `out_V_TVALID` equals `buf_v`.
- `out_V_TDATA` equals `buf[idx*OUT_WIDTH +: OUT_WIDTH]`. The mux is combinational from registers.
- `in0_V_TREADY` = !`buf_v` OR (`out_V_TREADY` AND `idx`==`RATIO`-1). This is a combinational path from `out_V_TREADY`, permitted by design.
- In-handshake (`in0_V_TVALID` AND `in0_V_TREADY`):
  - `buf` <= `in0_V_TDATA`, `idx` <= 0, `buf_v` <= 1.
  - Takes priority over the out-handshake update of `idx`/`buf_v` in the same cycle.
- Out-handshake with no in-handshake:
  - If `idx`==`RATIO`-1: `buf_v` <= 0, `idx` <= 0.
  - Otherwise: `idx` <= `idx`+1.
- With neither handshake, all state holds. The output is stable while `out_V_TVALID`=1 and `out_V_TREADY`=0 (AXI-Stream rule).
- `count` = `buf_v` ? (`RATIO` − `idx`) : 0.
- `RATIO`=1 degenerates to a single-register pipeline stage with full throughput. It must work without special-casing.
- `TDATA` of an input word presented without `TVALID` is ignored.

## Timing
- Reset values:
  - `buf_v`=0 and `idx`=0, so `out_V_TVALID`=0 and `count`=0.
  - `in0_V_TREADY`=1.
  - `buf` contents are don't-care, but reset to 0 for determinism.
  - Reset takes effect asynchronously. Asserting `ap_rst` mid-word discards the buffered slices immediately; no partial word is emitted after release.
- Latency: a word accepted at edge N presents slice 0 during cycle N+1.
- Throughput:
  - With `out_V_TREADY` held at 1 and input always valid, output is 1 slice per cycle continuously.
  - The input accepts one word every `RATIO` cycles.
  - The last slice of word k and acceptance of word k+1 happen at the same edge.
- Backpressure:
  - `in0_V_TREADY` stays low while slices other than the last remain.
  - When the last slice is held with `out_V_TREADY`=0, `in0_V_TREADY`=0.
- Full means `buf_v`=1 and `count`=`RATIO`. Empty means `count`=0.

## Structure
- No shared package is required. Derived constants (`RATIO`, `CNT_W`) are localparams.
- Elaboration-time assertion: `IN_WIDTH % OUT_WIDTH == 0` and `IN_WIDTH >= OUT_WIDTH`.
- Flat single module; no sub-module.
- The natural top-level pairing is `StreamingFIFO_N` `out_V` → `stream_dwc_down` `in0_V`. That wiring is done in the parent, not here.

## Test plan
- Reset, then a single word `72'hAAAAAA_BBBBBB_CCCCCC` with `out_V_TREADY`=1 → beats `CCCCCC`, `BBBBBB`, `AAAAAA` on cycles N+1..N+3. `count` reads 3, 2, 1, then 0.
- Back-to-back words `72'h000003_000002_000001` and `72'h000006_000005_000004`, ready always high → beats 1..6 on consecutive cycles. `in0_V_TREADY` pulses on the edge of beat 3.
- Hold `out_V_TREADY`=0 for 5 cycles mid-word at `idx`=1 → `TDATA` stays `BBBBBB`, `TVALID` stays 1, `in0_V_TREADY`=0, `count`=2 throughout. Sequence resumes correctly.
- Random valid/ready toggling over 1000 words → output stream equals the LSB-first concatenated input slices. No drops, no duplicates, no AXI-Stream stability violations.
- Assert `ap_rst` asynchronously while `count`=2 → `out_V_TVALID` and `count` go to 0 before the next edge. After release, the next input word is emitted from slice 0.
- Instance with `IN_WIDTH`=`OUT_WIDTH`=24 → each word is passed through with 1-cycle latency at full rate.

Source files
------------

// File: rtl/stream_dwc_down_pkg.sv
// Shared types and helpers for the stream width down-converter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package stream_dwc_down_pkg;

    // EMPTY: no unsent slices buffered. HOLD: buffer presents a slice.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Slice index width; a ratio of 1 still needs a 1-bit index so the
    // datapath elaborates without special-casing.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/stream_dwc_down.sv
// Splits each IN_WIDTH word into RATIO OUT_WIDTH beats, least-significant slice first.
// Latency: word accepted at edge N presents slice 0 in cycle N+1; one beat per cycle, no bubbles.
// Backpressure: input ready only when empty or when the last slice is being taken this cycle.
module stream_dwc_down
    import stream_dwc_down_pkg::*;
#(
    parameter int IN_WIDTH  = 72,
    parameter int OUT_WIDTH = 24,
    localparam int RATIO    = IN_WIDTH / OUT_WIDTH,
    localparam int CNT_W    = $clog2(RATIO + 1)
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [IN_WIDTH-1:0]  in0_V_TDATA,
    input  logic                 in0_V_TVALID,
    output logic                 in0_V_TREADY,
    output logic [OUT_WIDTH-1:0] out_V_TDATA,
    output logic                 out_V_TVALID,
    input  logic                 out_V_TREADY,
    output logic [CNT_W-1:0]     count
);

    localparam int                IDX_W    = idx_width(RATIO);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(RATIO - 1);

    // Reject widths that cannot be split into whole slices.
    if ((IN_WIDTH % OUT_WIDTH) != 0 || IN_WIDTH < OUT_WIDTH) begin : g_bad_width
        $error("stream_dwc_down: IN_WIDTH must be a positive multiple of OUT_WIDTH");
    end

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [IN_WIDTH-1:0] word_buf;
    logic                at_last;
    logic                in_hs;
    logic                out_hs;

    assign at_last = (idx == LAST_IDX);
    assign in_hs   = in0_V_TVALID && in0_V_TREADY;
    assign out_hs  = out_V_TVALID && out_V_TREADY;

    // State register: async reset clears the buffer so no partial word survives.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state    <= ST_EMPTY;
            idx      <= '0;
            word_buf <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (in_hs) begin
                word_buf <= in0_V_TDATA;
            end
        end
    end

    // Next state: a new word wins over advancing the slice index.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (in_hs) begin
            state_nxt = ST_HOLD;
            idx_nxt   = '0;
        end else if (out_hs) begin
            if (at_last) begin
                state_nxt = ST_EMPTY;
                idx_nxt   = '0;
            end else begin
                idx_nxt = idx + IDX_W'(1);
            end
        end
    end

    // Outputs: slice mux and flow control straight from registers, plus the
    // ready pass-through that lets the next word land on the last beat.
    always_comb begin
        out_V_TVALID = (state == ST_HOLD);
        in0_V_TREADY = (state == ST_EMPTY) || (out_V_TREADY && at_last);
        out_V_TDATA  = OUT_WIDTH'(word_buf >> (OUT_WIDTH * int'(idx)));
        count        = (state == ST_HOLD) ? (CNT_W'(RATIO) - CNT_W'(idx)) : '0;
    end

endmodule
